// File: rtl/mem_stage.sv
// Memory-access stage: runs ALU-stage load/store requests against data memory
// over a req/gnt/rvalid handshake and emits a one-cycle writeback record.

package mem_stage_pkg;
    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } access_size_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      mem_valid_i,
    input  logic                      mem_is_load_i,
    input  logic                      mem_is_store_i,
    input  logic                      mem_reg_wr_en_i,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result_i,
    input  logic [DATA_WIDTH-1:0]     mem_rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] mem_wr_reg_i,
    input  access_size_t              mem_access_size_i,
    output logic                      mem_stall_o,

    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   dmem_be_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,

    output logic                      wb_valid_o,
    output logic                      wb_reg_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      misaligned_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]                state;
    logic                      req_is_load;
    logic                      req_is_store;
    logic                      req_reg_wr_en;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [REGISTER_WIDTH-1:0] req_wr_reg;
    access_size_t              req_size;

    logic [1:0]                req_off;
    logic [BE_WIDTH-1:0]       req_be;
    logic [DATA_WIDTH-1:0]     req_wdata_fmt;
    logic [7:0]                load_byte;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      new_misaligned;

    assign req_off        = req_addr[1:0];
    assign new_misaligned = (mem_access_size_i == WORD) && (mem_alu_result_i[1:0] != 2'b00);

    always_comb begin
        req_be        = {BE_WIDTH{1'b1}};
        req_wdata_fmt = req_wdata;
        if (req_size == BYTE) begin
            req_be        = BE_WIDTH'(1) << req_off;
            req_wdata_fmt = {BE_WIDTH{req_wdata[7:0]}};
        end
    end

    // Byte loads pick the addressed lane and sign-extend it (LB semantics).
    always_comb begin
        load_byte = dmem_rdata_i[{req_off, 3'b000} +: 8];
        load_data = dmem_rdata_i;
        if (req_size == BYTE) begin
            load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
        end
    end

    assign mem_stall_o  = (state != S_IDLE);
    assign dmem_req_o   = (state == S_REQ);
    assign dmem_we_o    = (state == S_REQ) && req_is_store;
    assign dmem_addr_o  = (state == S_REQ) ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata_o = (state == S_REQ) ? req_wdata_fmt : '0;
    assign dmem_be_o    = (state == S_REQ) ? req_be : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            req_is_load    <= 1'b0;
            req_is_store   <= 1'b0;
            req_reg_wr_en  <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            req_wr_reg     <= '0;
            req_size       <= BYTE;
            wb_valid_o     <= 1'b0;
            wb_reg_wr_en_o <= 1'b0;
            wb_wr_reg_o    <= '0;
            wb_data_o      <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_wr_en_o <= 1'b0;
            misaligned_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_valid_i) begin
                        req_is_load   <= mem_is_load_i;
                        req_is_store  <= mem_is_store_i;
                        req_reg_wr_en <= mem_reg_wr_en_i;
                        req_addr      <= mem_alu_result_i[ADDR_WIDTH-1:0];
                        req_wdata     <= mem_rs2_data_i;
                        req_wr_reg    <= mem_wr_reg_i;
                        req_size      <= mem_access_size_i;
                        // Misaligned words never reach memory; report and retire at once.
                        if (new_misaligned) begin
                            misaligned_o <= 1'b1;
                            wb_valid_o   <= 1'b1;
                            wb_wr_reg_o  <= mem_wr_reg_i;
                            wb_data_o    <= '0;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        if (req_is_load) begin
                            state <= S_WAIT;
                        end else begin
                            state       <= S_IDLE;
                            wb_valid_o  <= 1'b1;
                            wb_wr_reg_o <= req_wr_reg;
                            wb_data_o   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        state          <= S_IDLE;
                        wb_valid_o     <= 1'b1;
                        wb_reg_wr_en_o <= req_reg_wr_en;
                        wb_wr_reg_o    <= req_wr_reg;
                        wb_data_o      <= load_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multi-cycle core. Takes the load/store request produced by the ALU stage (address, store data, access size, destination register) and runs it against the data memory over a request/grant/response handshake. It formats byte and word accesses, back-pressures the ALU stage with `mem_stall_o`, and delivers a one-cycle writeback record when each access completes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data/register width (byte lanes = DATA_WIDTH/8 = 4)
- `ADDR_WIDTH`, 32, byte address width
- `REGISTER_WIDTH`, 5, register index width

Ports. One clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `mem_valid_i`  in  1  request valid from ALU stage
- `mem_is_load_i` / `mem_is_store_i`  in  1  access type (exactly one set when valid)
- `mem_reg_wr_en_i`  in  1  destination write enable
- `mem_alu_result_i`  in  DATA_WIDTH  byte address
- `mem_rs2_data_i`  in  DATA_WIDTH  store data
- `mem_wr_reg_i`  in  REGISTER_WIDTH  destination register
- `mem_access_size_i`  in  access_size_t  BYTE or WORD
- `mem_stall_o`  out  1  ALU stage must hold its outputs
- `dmem_req_o`  out  1  memory request
- `dmem_we_o`  out  1  1 = store
- `dmem_addr_o`  out  ADDR_WIDTH  word-aligned address
- `dmem_wdata_o`  out  DATA_WIDTH  store data
- `dmem_be_o`  out  4  byte enables
- `dmem_gnt_i`  in  1  request accepted
- `dmem_rvalid_i`  in  1  load data valid
- `dmem_rdata_i`  in  DATA_WIDTH  load data
- `wb_valid_o`  out  1  access completed (1-cycle pulse)
- `wb_reg_wr_en_o`  out  1  write `wb_data_o` to `wb_wr_reg_o`
- `wb_wr_reg_o`  out  REGISTER_WIDTH  destination register
- `wb_data_o`  out  DATA_WIDTH  load result
- `misaligned_o`  out  1  1-cycle pulse: misaligned WORD access dropped

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: when `mem_valid_i`=1, latch all request fields. If the access is WORD and `addr[1:0]`≠0, stay in IDLE and next cycle pulse `misaligned_o`=1 and `wb_valid_o`=1 with `wb_reg_wr_en_o`=0. No memory request is issued. Otherwise go to REQ.
- REQ: `dmem_req_o`=1 and all `dmem_*` outputs are driven from the latched fields, held stable until grant. On `dmem_gnt_i`: a store goes to IDLE and pulses writeback next cycle with `wb_reg_wr_en_o`=0; a load goes to WAIT.
- WAIT: on `dmem_rvalid_i`, go to IDLE. Next cycle pulse `wb_valid_o`, with `wb_reg_wr_en_o` = latched `mem_reg_wr_en_i` and `wb_data_o` = formatted data.
- `mem_stall_o` = (state ≠ IDLE), combinational.
- Address: `dmem_addr_o` = {addr[ADDR_WIDTH-1:2], 2'b00}; off = addr[1:0].
- WORD store: `dmem_be_o`=4'b1111, `dmem_wdata_o`=rs2.
- BYTE store: `dmem_be_o`=4'b0001<<off, `dmem_wdata_o`={4{rs2[7:0]}}.
- Loads: `dmem_we_o`=0, `dmem_be_o` as for stores of the same size.
- WORD load result: rdata.
- BYTE load result: sign-extend rdata[8·off+7 : 8·off] (LB semantics).
- Ignored inputs: `mem_valid_i` outside IDLE (upstream holds while stalled); `dmem_gnt_i` outside REQ; `dmem_rvalid_i` outside WAIT.

## Timing
- Reset: state IDLE; all outputs 0 (`mem_stall_o`, all `dmem_*`, all `wb_*`, `misaligned_o`).
- Reset mid-operation: the FSM returns to IDLE at once and `dmem_req_o` drops. A late `dmem_rvalid_i` after reset is ignored and produces no writeback.
- `wb_*` and `misaligned_o` are registered. `wb_valid_o` is high for exactly one cycle per accepted request.
- Load with same-cycle grant and response one cycle later: capture at C0, req+gnt at C1, rvalid at C2, `wb_valid_o` at C3. Stall is high in C1–C2.
- Store with immediate grant: capture at C0, req+gnt at C1, `wb_valid_o` at C2. Stall is high in C1.
- Each extra cycle without grant or rvalid adds one stall cycle.
- `dmem_rvalid_i` never arrives in the grant cycle.
- A new request can be captured in the same cycle that `wb_valid_o` pulses for the previous one (back-to-back).

## Test plan
- Word load: addr 0x100, gnt at C1, rvalid at C2 with 0xDEADBEEF, rd=5 → `wb_valid_o`=1 at C3, `wb_data_o`=0xDEADBEEF, `wb_wr_reg_o`=5, `wb_reg_wr_en_o`=1; stall high exactly C1–C2.
- Byte load: addr 0x103, rdata 0x80123456 → `dmem_be_o`=4'b1000, `wb_data_o`=0xFFFFFF80. Addr 0x101 with the same rdata → 0x00000034.
- Byte store: addr 0x202, rs2 0x000000AB, gnt delayed 3 cycles → req held stable with addr 0x200, be 4'b0100, wdata 0xABABABAB; `wb_valid_o` the cycle after gnt with `wb_reg_wr_en_o`=0.
- Misaligned WORD load at 0x102 → `dmem_req_o` never asserted; `misaligned_o` and `wb_valid_o` pulse next cycle with `wb_reg_wr_en_o`=0; stall stays 0.
- `rst_i` asserted in WAIT, then `dmem_rvalid_i` the following cycle → all outputs 0, no `wb_valid_o`, state IDLE.
- Back-to-back store then load with immediate grant → second request captured on the cycle stall drops; exactly two `wb_valid_o` pulses, in order.
